// File: rtl/sync_fifo_mem_if.sv
// Bus bundle for sync_fifo_mem.
//   winc/wdata      : write request and data (master -> fifo)
//   rinc            : pop request             (master -> fifo)
//   err_clr         : clear sticky ovf/udf    (master -> fifo)
//   rdata           : show-ahead head word    (fifo -> master)
//   wfull/rempty    : full / empty flags      (fifo -> master)
//   afull/aempty    : almost-full / almost-empty flags
//   count           : occupancy 0..DEPTH
//   ovf/udf         : sticky overflow / underflow flags
interface sync_fifo_mem_if #(
  parameter int data = 14,
  parameter int addr = 4
);
  logic            winc;
  logic [data-1:0] wdata;
  logic            rinc;
  logic            err_clr;
  logic [data-1:0] rdata;
  logic            wfull;
  logic            rempty;
  logic            afull;
  logic            aempty;
  logic [addr:0]   count;
  logic            ovf;
  logic            udf;

  modport slave (
    input  winc, wdata, rinc, err_clr,
    output rdata, wfull, rempty, afull, aempty, count, ovf, udf
  );

  modport master (
    output winc, wdata, rinc, err_clr,
    input  rdata, wfull, rempty, afull, aempty, count, ovf, udf
  );
endinterface

// File: rtl/sync_fifo_mem.sv
// Single-clock show-ahead FIFO with occupancy count, almost flags and
// sticky overflow/underflow error flags.
//   wclk : clock, all state updates on rising edge
//   wrst : asynchronous active-high reset (pointers, count, error flags)
//   bus  : sync_fifo_mem_if.slave -- write/read handshake, data, flags, count
module sync_fifo_mem #(
  parameter int data      = 14,
  parameter int addr      = 4,
  parameter int AFULL_TH  = (1 << addr) - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic             wclk,
  input  logic             wrst,
  sync_fifo_mem_if.slave   bus
);

  localparam int            DEPTH   = 1 << addr;
  localparam logic [addr:0] W_DEPTH = (addr+1)'(DEPTH);
  localparam logic [addr:0] W_AF    = (addr+1)'(AFULL_TH);
  localparam logic [addr:0] W_AE    = (addr+1)'(AEMPTY_TH);

  logic [data-1:0] r_mem [DEPTH];
  logic [addr-1:0] r_wptr;
  logic [addr-1:0] r_rptr;
  logic [addr:0]   r_count;
  logic            r_ovf;
  logic            r_udf;

  logic w_full;
  logic w_empty;
  logic w_wr_ok;
  logic w_rd_ok;

  assign w_full  = (r_count == W_DEPTH);
  assign w_empty = (r_count == '0);
  assign w_wr_ok = bus.winc & ~w_full;
  assign w_rd_ok = bus.rinc & ~w_empty;

  // Storage is intentionally not reset; reset only discards contents logically.
  always_ff @(posedge wclk) begin
    if (w_wr_ok) r_mem[r_wptr] <= bus.wdata;
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + addr'(1);
      if (w_rd_ok) r_rptr <= r_rptr + addr'(1);
      case ({w_wr_ok, w_rd_ok})
        2'b10:   r_count <= r_count + (addr+1)'(1);
        2'b01:   r_count <= r_count - (addr+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags: a new error in the same cycle as err_clr wins.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (bus.winc & w_full)      r_ovf <= 1'b1;
      else if (bus.err_clr)       r_ovf <= 1'b0;
      if (bus.rinc & w_empty)     r_udf <= 1'b1;
      else if (bus.err_clr)       r_udf <= 1'b0;
    end
  end

  assign bus.rdata  = r_mem[r_rptr];
  assign bus.wfull  = w_full;
  assign bus.rempty = w_empty;
  assign bus.afull  = (r_count >= W_AF);
  assign bus.aempty = (r_count <= W_AE);
  assign bus.count  = r_count;
  assign bus.ovf    = r_ovf;
  assign bus.udf    = r_udf;

endmodule

// File: tb/tb_sync_fifo_mem.sv
module tb_sync_fifo_mem;
  localparam int DW    = 14;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic wclk = 1'b0;
  logic wrst = 1'b0;

  sync_fifo_mem_if #(.data(DW), .addr(AW)) bus ();

  sync_fifo_mem #(
    .data(DW), .addr(AW), .AFULL_TH(14), .AEMPTY_TH(2)
  ) dut (
    .wclk(wclk),
    .wrst(wrst),
    .bus (bus)
  );

  always #5 wclk = ~wclk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Reference model: a plain queue plus two sticky bits.
  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge wclk or posedge wrst) begin
    bit full, empty, wok, rok;
    if (wrst) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      full  = (q.size() == DEPTH);
      empty = (q.size() == 0);
      wok   = bus.winc && !full;
      rok   = bus.rinc && !empty;
      if (bus.winc && full)       m_ovf = 1'b1;
      else if (bus.err_clr)       m_ovf = 1'b0;
      if (bus.rinc && empty)      m_udf = 1'b1;
      else if (bus.err_clr)       m_udf = 1'b0;
      if (rok) void'(q.pop_front());
      if (wok) q.push_back(bus.wdata);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge wclk) begin
    check("count",  bus.count,  q.size());
    check("wfull",  bus.wfull,  q.size() == DEPTH);
    check("rempty", bus.rempty, q.size() == 0);
    check("afull",  bus.afull,  q.size() >= 14);
    check("aempty", bus.aempty, q.size() <= 2);
    check("ovf",    bus.ovf,    m_ovf);
    check("udf",    bus.udf,    m_udf);
    if (q.size() != 0) check("rdata", bus.rdata, q[0]);
  end

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r, input logic clr);
    bus.winc    = w;
    bus.wdata   = d;
    bus.rinc    = r;
    bus.err_clr = clr;
    @(posedge wclk);
    @(negedge wclk);
  endtask

  initial begin
    bus.winc    = 1'b0;
    bus.wdata   = '0;
    bus.rinc    = 1'b0;
    bus.err_clr = 1'b0;
    #1 wrst = 1'b1;
    #1;
    check("rst_count",  bus.count,  0);
    check("rst_rempty", bus.rempty, 1);
    check("rst_aempty", bus.aempty, 1);
    check("rst_wfull",  bus.wfull,  0);
    check("rst_afull",  bus.afull,  0);
    check("rst_ovf",    bus.ovf,    0);
    check("rst_udf",    bus.udf,    0);
    @(negedge wclk);
    wrst = 1'b0;

    // Fill 0x0001..0x0010, watching threshold crossings.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, DW'(i), 1'b0, 1'b0);
      if (i == 1)  check("first_wr_count", bus.count, 1);
      if (i == 2)  check("aempty_at2",  bus.aempty, 1);
      if (i == 3)  check("aempty_at3",  bus.aempty, 0);
      if (i == 13) check("afull_at13",  bus.afull,  0);
      if (i == 14) check("afull_at14",  bus.afull,  1);
    end
    check("fill_count", bus.count, 16);
    check("fill_wfull", bus.wfull, 1);
    for (int i = 1; i <= 16; i++) begin
      check("drain_rdata", bus.rdata, i);
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    check("drain_rempty", bus.rempty, 1);
    check("drain_count",  bus.count,  0);

    // Overflow: write while full is dropped.
    for (int i = 1; i <= 16; i++) cyc(1'b1, DW'(16'h100 + i), 1'b0, 1'b0);
    cyc(1'b1, 14'h3FFF, 1'b0, 1'b0);
    check("ovf_set",   bus.ovf,   1);
    check("ovf_count", bus.count, 16);
    check("ovf_head",  bus.rdata, 16'h101);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("ovf_clr",   bus.ovf,   0);
    // Full with both requests: read wins, write rejected.
    cyc(1'b1, 14'h1234, 1'b1, 1'b0);
    check("full_rw_count", bus.count, 15);
    check("full_rw_ovf",   bus.ovf,   1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    for (int i = 2; i <= 16; i++) begin
      check("ovf_drain", bus.rdata, 16'h100 + i);
      cyc(1'b0, '0, 1'b1, 1'b0);
    end
    check("ovf_drain_empty", bus.rempty, 1);

    // Underflow: read when empty with a write.
    cyc(1'b1, 14'h2AAA, 1'b1, 1'b0);
    check("udf_set",   bus.udf,   1);
    check("udf_count", bus.count, 1);
    check("udf_rdata", bus.rdata, 16'h2AAA);
    cyc(1'b0, '0, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 1'b1);
    check("udf_set_wins", bus.udf, 1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    check("udf_clr", bus.udf, 0);

    // Steady state at 8 with simultaneous read/write.
    for (int i = 0; i < 8; i++) cyc(1'b1, DW'(16'h200 + i), 1'b0, 1'b0);
    for (int k = 0; k < 40; k++) begin
      cyc(1'b1, DW'(16'h208 + k), 1'b1, 1'b0);
      check("rw_count", bus.count, 8);
      check("rw_head",  bus.rdata, 16'h200 + k + 1);
    end
    for (int j = 0; j < 8; j++) begin
      check("rw_drain", bus.rdata, 16'h228 + j);
      cyc(1'b0, '0, 1'b1, 1'b0);
    end

    // Mid-cycle reset at count 9 with ovf set.
    for (int i = 0; i < 16; i++) cyc(1'b1, DW'(16'h300 + i), 1'b0, 1'b0);
    cyc(1'b1, 14'h0777, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b1, 1'b0);
    check("pre_rst_count", bus.count, 9);
    check("pre_rst_ovf",   bus.ovf,   1);
    #2 wrst = 1'b1;
    #1;
    check("mid_rst_count",  bus.count,  0);
    check("mid_rst_rempty", bus.rempty, 1);
    check("mid_rst_ovf",    bus.ovf,    0);
    check("mid_rst_wfull",  bus.wfull,  0);
    #1 wrst = 1'b0;
    cyc(1'b1, 14'h0555, 1'b0, 1'b0);
    check("post_rst_count", bus.count, 1);
    check("post_rst_rdata", bus.rdata, 16'h0555);
    cyc(1'b0, '0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
